// File: rtl/mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mon_pkg
// Description : Shared definitions for the monitor / CPU / trash DRAM
//               arbiter: arbiter state encoding and requester IDs used for
//               the round-robin pointer and the read-return tag.
// Revision    : 1.0 - initial release
// ============================================================================
package mon_pkg;

  // Arbiter states
  typedef enum logic [1:0] {
    ARB_RR    = 2'd0,
    ARB_LOCK  = 2'd1,
    ARB_TRASH = 2'd2
  } arb_state_e;

  // Requester IDs (round-robin pointer and read tag)
  localparam logic MON = 1'b0;
  localparam logic CPU = 1'b1;

endpackage : mon_pkg
`default_nettype wire

// File: rtl/mon_dram_arb.sv
`default_nettype none
// ============================================================================
// Module      : mon_dram_arb
// Description : Three-port arbiter in front of a single-port data RAM.
//               Monitor and CPU share the RAM round-robin; the monitor may
//               lock the RAM for up to LOCK_MAX consecutive grants; the
//               write-only trash port pre-empts both while it requests
//               (except during a monitor lock). Read data returns one cycle
//               after a read grant, tagged to the requester that issued it.
// Ports       : clk, rst_n                       - clock, async active-low reset
//               mon_req/we/lock/adr/wdata        - monitor request
//               mon_gnt, mon_rvalid              - monitor grant / read return
//               cpu_req/we/adr/wdata             - CPU request
//               cpu_gnt, cpu_rvalid              - CPU grant / read return
//               trs_req/adr, trs_gnt             - trash (zero-write) port
//               ram_adr/wdata/wen/ren, ram_rdata - RAM side (1-cycle read)
//               rdata                            - returned read data
// Revision    : 1.0 - initial release
// ============================================================================
module mon_dram_arb
  import mon_pkg::*;
#(
  parameter int DWIDTH   = 11,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mon_req,
  input  logic              mon_we,
  input  logic              mon_lock,
  input  logic [DWIDTH+1:2] mon_adr,
  input  logic [31:0]       mon_wdata,
  output logic              mon_gnt,
  output logic              mon_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [DWIDTH+1:2] cpu_adr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              trs_req,
  input  logic [DWIDTH+1:2] trs_adr,
  output logic              trs_gnt,
  output logic [DWIDTH+1:2] ram_adr,
  output logic [31:0]       ram_wdata,
  output logic              ram_wen,
  output logic              ram_ren,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       rdata
);

  localparam int               CNT_W      = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] C_LOCK_MAX = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  arb_state_e       r_state;
  logic             r_rr_last;
  logic [CNT_W-1:0] r_lock_cnt;
  logic             r_tag_vld;
  logic             r_tag_id;

  logic             w_gnt_mon;
  logic             w_gnt_cpu;
  logic             w_gnt_trs;

  // Grant decode. Grants are forced low while reset is asserted so the RAM
  // sees no access during reset regardless of the request inputs.
  always_comb begin
    w_gnt_mon = 1'b0;
    w_gnt_cpu = 1'b0;
    w_gnt_trs = 1'b0;
    if (rst_n) begin
      case (r_state)
        ARB_RR: begin
          if (trs_req) begin
            w_gnt_trs = 1'b1;
          end else if (mon_req && cpu_req) begin
            // Tie: the port that did not win last time goes first
            if (r_rr_last == MON) w_gnt_cpu = 1'b1;
            else                  w_gnt_mon = 1'b1;
          end else begin
            w_gnt_mon = mon_req;
            w_gnt_cpu = cpu_req;
          end
        end
        ARB_LOCK: begin
          // Lock expiry hands the RAM to a waiting CPU in the same cycle
          if (mon_req) begin
            if (mon_lock && (r_lock_cnt == C_LOCK_MAX) && cpu_req) w_gnt_cpu = 1'b1;
            else                                                    w_gnt_mon = 1'b1;
          end
        end
        ARB_TRASH: begin
          w_gnt_trs = trs_req;
        end
        default: ;
      endcase
    end
  end

  assign mon_gnt = w_gnt_mon;
  assign cpu_gnt = w_gnt_cpu;
  assign trs_gnt = w_gnt_trs;

  // RAM-side mux; the trash port always writes zero
  always_comb begin
    ram_adr   = '0;
    ram_wdata = 32'd0;
    ram_wen   = 1'b0;
    ram_ren   = 1'b0;
    if (w_gnt_mon) begin
      ram_adr   = mon_adr;
      ram_wdata = mon_wdata;
      ram_wen   = mon_we;
      ram_ren   = ~mon_we;
    end else if (w_gnt_cpu) begin
      ram_adr   = cpu_adr;
      ram_wdata = cpu_wdata;
      ram_wen   = cpu_we;
      ram_ren   = ~cpu_we;
    end else if (w_gnt_trs) begin
      ram_adr   = trs_adr;
      ram_wen   = 1'b1;
    end
  end

  // State, round-robin pointer, lock counter and read tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB_RR;
      r_rr_last  <= MON;
      r_lock_cnt <= '0;
      r_tag_vld  <= 1'b0;
      r_tag_id   <= MON;
    end else begin
      case (r_state)
        ARB_RR: begin
          if (w_gnt_trs) begin
            r_state <= ARB_TRASH;
          end else if (w_gnt_mon && mon_lock) begin
            r_state    <= ARB_LOCK;
            r_lock_cnt <= C_CNT_ONE;
          end
        end
        ARB_LOCK: begin
          if (!mon_req || !mon_lock || w_gnt_cpu) begin
            r_state    <= ARB_RR;
            r_lock_cnt <= '0;
          end else if (r_lock_cnt != C_LOCK_MAX) begin
            r_lock_cnt <= r_lock_cnt + C_CNT_ONE;
          end
        end
        ARB_TRASH: begin
          if (!trs_req) r_state <= ARB_RR;
        end
        default: r_state <= ARB_RR;
      endcase

      if (w_gnt_mon)      r_rr_last <= MON;
      else if (w_gnt_cpu) r_rr_last <= CPU;

      // Trash never reads, so a read grant belongs to the monitor or the CPU
      r_tag_vld <= ram_ren;
      r_tag_id  <= w_gnt_cpu ? CPU : MON;
    end
  end

  assign mon_rvalid = r_tag_vld && (r_tag_id == MON);
  assign cpu_rvalid = r_tag_vld && (r_tag_id == CPU);
  assign rdata      = r_tag_vld ? ram_rdata : 32'd0;

endmodule : mon_dram_arb
`default_nettype wire

// File: tb/tb_mon_dram_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mon_dram_arb
// Description : Self-checking bench for mon_dram_arb. A reference model
//               predicts every cycle's outputs into a queue; a negedge
//               monitor pops and compares. Directed sequences plus random
//               traffic; a behavioural RAM returns an address hash.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mon_dram_arb;

  localparam int DW   = 11;
  localparam int LMAX = 16;

  typedef struct packed {
    logic          mg, cg, tg, wen, ren;
    logic [DW+1:2] adr;
    logic [31:0]   wd;
    logic          mrv, crv;
    logic [31:0]   rd;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mon_req = 0, mon_we = 0, mon_lock = 0;
  logic [DW+1:2] mon_adr = '0;
  logic [31:0]   mon_wdata = '0;
  logic          mon_gnt, mon_rvalid;
  logic          cpu_req = 0, cpu_we = 0;
  logic [DW+1:2] cpu_adr = '0;
  logic [31:0]   cpu_wdata = '0;
  logic          cpu_gnt, cpu_rvalid;
  logic          trs_req = 0;
  logic [DW+1:2] trs_adr = '0;
  logic          trs_gnt;
  logic [DW+1:2] ram_adr;
  logic [31:0]   ram_wdata;
  logic          ram_wen, ram_ren;
  logic [31:0]   ram_rdata = '0;
  logic [31:0]   rdata;

  int n_checks = 0;
  int n_errors = 0;
  int n_mg = 0, n_cg = 0, n_tg = 0, n_crv = 0;

  exp_t exp_q[$];

  mon_dram_arb #(.DWIDTH(DW), .LOCK_MAX(LMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .mon_req(mon_req), .mon_we(mon_we), .mon_lock(mon_lock),
    .mon_adr(mon_adr), .mon_wdata(mon_wdata),
    .mon_gnt(mon_gnt), .mon_rvalid(mon_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .trs_req(trs_req), .trs_adr(trs_adr), .trs_gnt(trs_gnt),
    .ram_adr(ram_adr), .ram_wdata(ram_wdata), .ram_wen(ram_wen),
    .ram_ren(ram_ren), .ram_rdata(ram_rdata), .rdata(rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [DW+1:2] a);
    logic [31:0] x;
    x = 32'(a);
    return (x * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // Behavioural RAM: registered read of an address-derived pattern
  always @(posedge clk) if (ram_ren) ram_rdata <= memval(ram_adr);

  // ---------------- reference model ----------------
  // mode: 0 = shared, 1 = monitor holds the RAM, 2 = trash burst
  int          m_mode = 0;
  int          m_run = 0;        // grants in the current monitor lock
  bit          m_last_cpu = 0;   // last of mon/cpu to be served was the CPU
  bit          m_pend = 0, m_pend_cpu = 0;
  logic [31:0] m_pend_data = '0;

  task automatic model_step();
    exp_t e;
    int   win;   // 0 none, 1 monitor, 2 cpu, 3 trash
    e = '0;
    if (!rst_n) begin
      m_mode = 0; m_run = 0; m_last_cpu = 0; m_pend = 0;
      exp_q.push_back(e);
      return;
    end
    e.mrv = m_pend && !m_pend_cpu;
    e.crv = m_pend && m_pend_cpu;
    e.rd  = m_pend ? m_pend_data : 32'd0;
    win = 0;
    if (m_mode == 0) begin
      if (trs_req) begin win = 3; m_mode = 2; end
      else if (mon_req && cpu_req) win = m_last_cpu ? 1 : 2;
      else if (mon_req) win = 1;
      else if (cpu_req) win = 2;
      if (win == 1 && mon_lock) begin m_mode = 1; m_run = 1; end
    end else if (m_mode == 1) begin
      if (!mon_req) begin m_mode = 0; end
      else if (!mon_lock) begin win = 1; m_mode = 0; end
      else if (m_run >= LMAX && cpu_req) begin win = 2; m_mode = 0; end
      else begin win = 1; if (m_run < LMAX) m_run++; end
    end else begin
      if (trs_req) win = 3;
      else m_mode = 0;
    end
    if (win == 1) m_last_cpu = 0;
    if (win == 2) m_last_cpu = 1;
    case (win)
      1: begin e.mg = 1; e.adr = mon_adr; e.wen = mon_we; e.ren = !mon_we; e.wd = mon_wdata; end
      2: begin e.cg = 1; e.adr = cpu_adr; e.wen = cpu_we; e.ren = !cpu_we; e.wd = cpu_wdata; end
      3: begin e.tg = 1; e.adr = trs_adr; e.wen = 1; e.wd = 32'd0; end
      default: ;
    endcase
    exp_q.push_back(e);
    m_pend      = e.ren;
    m_pend_cpu  = (win == 2);
    m_pend_data = memval(e.adr);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e, a;
    n_mg  += int'(mon_gnt);
    n_cg  += int'(cpu_gnt);
    n_tg  += int'(trs_gnt);
    n_crv += int'(cpu_rvalid);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.mg = mon_gnt; a.cg = cpu_gnt; a.tg = trs_gnt;
      a.wen = ram_wen; a.ren = ram_ren; a.adr = ram_adr; a.wd = ram_wdata;
      a.mrv = mon_rvalid; a.crv = cpu_rvalid; a.rd = rdata;
      // Write data on a read grant carries no meaning
      if (e.ren) begin e.wd = '0; a.wd = '0; end
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL outputs @%0t: got gnt(m/c/t)=%b%b%b wen=%b ren=%b adr=%h wd=%h rv(m/c)=%b%b rd=%h, expected gnt=%b%b%b wen=%b ren=%b adr=%h wd=%h rv=%b%b rd=%h",
                 $time, a.mg, a.cg, a.tg, a.wen, a.ren, a.adr, a.wd, a.mrv, a.crv, a.rd,
                 e.mg, e.cg, e.tg, e.wen, e.ren, e.adr, e.wd, e.mrv, e.crv, e.rd);
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // One clock of stimulus, applied just after the rising edge
  task automatic cyc(input bit r, input bit mr, input bit mw, input bit ml,
                     input bit cr, input bit cw, input bit tr,
                     input logic [DW+1:2] ma, input logic [DW+1:2] ca,
                     input logic [DW+1:2] ta, input logic [31:0] cwd);
    @(posedge clk);
    #1;
    rst_n = r;
    mon_req = mr; mon_we = mw; mon_lock = ml; mon_adr = ma; mon_wdata = $urandom;
    cpu_req = cr; cpu_we = cw; cpu_adr = ca; cpu_wdata = cwd;
    trs_req = tr; trs_adr = ta;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, '0, '0, '0, 32'd0);
  endtask

  initial begin
    int s_m, s_c, s_t, s_rv;

    // Reset: all outputs idle even with requests present
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, 1, 0, 1, 11'h12, 11'h34, 11'h56, 32'h1);
    idle(1);

    // Tie after reset: CPU first, then monitor, rvalids back to back
    s_m = n_mg; s_c = n_cg;
    cyc(1, 1, 0, 0, 1, 0, 0, 11'h005, 11'h009, '0, 32'd0);
    @(negedge clk); #1;
    check("tie_first_cpu", n_cg - s_c, 1);
    check("tie_first_mon", n_mg - s_m, 0);
    cyc(1, 1, 0, 0, 1, 0, 0, 11'h005, 11'h009, '0, 32'd0);
    idle(2);

    // CPU write: no read return
    s_rv = n_crv;
    cyc(1, 0, 0, 0, 1, 1, 0, '0, 11'h3FF, '0, 32'hDEAD_BEEF);
    @(negedge clk); #1;
    check("wr_wen", int'(ram_wen), 1);
    check("wr_adr", int'(ram_adr), 32'h3FF);
    check("wr_wdata_ok", int'(ram_wdata == 32'hDEAD_BEEF), 1);
    idle(3);
    check("wr_no_rvalid", n_crv - s_rv, 0);

    // Lock timeout: 16 monitor grants, then the CPU on cycle 17
    s_m = n_mg; s_c = n_cg;
    for (int i = 0; i < 17; i++) cyc(1, 1, 0, 1, 1, 0, 0, 11'(i), 11'(100 + i), '0, 32'd0);
    @(negedge clk); #1;
    check("lock_mon_grants", n_mg - s_m, 16);
    check("lock_cpu_grants", n_cg - s_c, 1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 1, 1, 0, 0, 11'(i), 11'(200 + i), '0, 32'd0);
    idle(2);

    // Trash pre-emption over the whole address range
    s_m = n_mg; s_c = n_cg; s_t = n_tg;
    for (int i = 0; i < 2048; i++) cyc(1, 1, 0, 0, 1, 0, 1, 11'h7, 11'h8, 11'(i), 32'd0);
    @(negedge clk); #1;
    check("trash_grants", n_tg - s_t, 2048);
    check("trash_mon_blocked", n_mg - s_m, 0);
    check("trash_cpu_blocked", n_cg - s_c, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 1, 0, 0, 11'h7, 11'h8, '0, 32'd0);
    idle(1);

    // Trash raised during a lock is held until the lock is released
    cyc(1, 1, 0, 1, 0, 0, 0, 11'h20, '0, '0, 32'd0);
    s_t = n_tg;
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1, 0, 0, 1, 11'(33 + i), '0, 11'h40, 32'd0);
    @(negedge clk); #1;
    check("lock_trash_held", n_tg - s_t, 0);
    cyc(1, 1, 0, 0, 0, 0, 1, 11'h25, '0, 11'h41, 32'd0);
    cyc(1, 0, 0, 0, 0, 0, 1, '0, '0, 11'h42, 32'd0);
    @(negedge clk); #1;
    check("lock_trash_after", n_tg - s_t, 1);
    idle(2);

    // Reset pulse right after a CPU read grant drops the read return
    cyc(1, 0, 0, 0, 1, 0, 0, '0, 11'h77, '0, 32'd0);
    s_rv = n_crv;
    cyc(0, 0, 0, 0, 0, 0, 0, '0, '0, '0, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, '0, '0, '0, 32'd0);
    idle(3);
    check("rst_drops_rvalid", n_crv - s_rv, 0);

    // Random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 299) != 0,
          1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
          1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
          11'($urandom), 11'($urandom), 11'($urandom), $urandom);
    end
    idle(3);
    @(negedge clk); #1;
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mon_dram_arb
`default_nettype wire
